// File: rtl/playseq_condiciona_entradas.sv
// PlaySeq input conditioning: 2-flop sync, per-lane debounce,
// single-button filter for botoes and a one-shot start pulse.
module playseq_condiciona_entradas #(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int CW = $clog2(DEBOUNCE_CYCLES)
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [3:0] botoes_raw,
   input  logic       jogar_raw,
   output logic [3:0] botoes,
   output logic       jogar,
   output logic [4:0] db_estavel,
   output logic       db_multipla,
   output logic [1:0] db_estado
);

   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      LIVRE       = 2'd0,
      PRESSIONADO = 2'd1,
      BLOQUEADO   = 2'd2
   } estado_t;

   logic [4:0] raw;
   logic [4:0] s1;
   logic [4:0] s2;
   logic [4:0] est;
   logic       est_j_prev;
   estado_t    estado;
   logic [3:0] trava;
   logic [3:0] e;
   logic       vazio;
   logic       unico;

   assign raw = {jogar_raw, botoes_raw};

   // Two-flop synchronizer for all five raw inputs
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         s1 <= '0;
         s2 <= '0;
      end else begin
         s1 <= raw;
         s2 <= s1;
      end
   end

   for (genvar i = 0; i < 5; i++) begin : g_lane
      logic [CW-1:0] cnt;
      logic          est_l;

      // Accept a new level only after it held for DEBOUNCE_CYCLES edges
      always_ff @(posedge clock or negedge reset) begin
         if (!reset) begin
            cnt   <= '0;
            est_l <= 1'b0;
         end else if (s2[i] == est_l) begin
            cnt <= '0;
         end else if (cnt == CNT_MAX) begin
            est_l <= s2[i];
            cnt   <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end

      assign est[i] = est_l;
   end

   // Rising-edge detector on the debounced start key
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         est_j_prev <= 1'b0;
         jogar      <= 1'b0;
      end else begin
         est_j_prev <= est[4];
         jogar      <= est[4] & ~est_j_prev;
      end
   end

   assign e     = est[3:0];
   assign vazio = (e == 4'd0);
   assign unico = !vazio && ((e & (e - 4'd1)) == 4'd0);

   // Single-button filter: any multi-press blocks until all released
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         estado <= LIVRE;
         botoes <= '0;
         trava  <= '0;
      end else begin
         case (estado)
            LIVRE: begin
               if (unico) begin
                  trava  <= e;
                  botoes <= e;
                  estado <= PRESSIONADO;
               end else if (!vazio) begin
                  botoes <= '0;
                  estado <= BLOQUEADO;
               end else begin
                  botoes <= '0;
               end
            end
            PRESSIONADO: begin
               if (e == trava) begin
                  botoes <= trava;
               end else if (vazio) begin
                  botoes <= '0;
                  estado <= LIVRE;
               end else begin
                  botoes <= '0;
                  estado <= BLOQUEADO;
               end
            end
            BLOQUEADO: begin
               botoes <= '0;
               if (vazio) estado <= LIVRE;
            end
            default: begin
               botoes <= '0;
               estado <= LIVRE;
            end
         endcase
      end
   end

   assign db_estavel  = est;
   assign db_multipla = (estado == BLOQUEADO);
   assign db_estado   = estado;

endmodule

// File: tb/tb_playseq_condiciona_entradas.sv
// Self-checking bench for playseq_condiciona_entradas.
// Reference model works on sample windows and press rules.
module tb_playseq_condiciona_entradas;

   localparam int D = 4;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic [3:0] botoes_raw = 4'd0;
   logic       jogar_raw = 1'b0;
   logic [3:0] botoes;
   logic       jogar;
   logic [4:0] db_estavel;
   logic       db_multipla;
   logic [1:0] db_estado;

   int checks = 0;
   int errors = 0;

   playseq_condiciona_entradas #(.DEBOUNCE_CYCLES(D)) dut (
      .clock      (clock),
      .reset      (reset),
      .botoes_raw (botoes_raw),
      .jogar_raw  (jogar_raw),
      .botoes     (botoes),
      .jogar      (jogar),
      .db_estavel (db_estavel),
      .db_multipla(db_multipla),
      .db_estado  (db_estado)
   );

   always #5 clock = ~clock;

   // reference model state
   logic [4:0] sq[$];
   logic [4:0] win[$];
   logic [4:0] m_est = 5'd0;
   logic       m_prev4 = 1'b0;
   logic       m_jogar = 1'b0;
   logic [3:0] m_botoes = 4'd0;
   logic       m_blocked = 1'b0;

   initial begin
      sq.push_back(5'd0);
      sq.push_back(5'd0);
   end

   // Level accepted once the last D synchronized samples all disagree
   always @(posedge clock or negedge reset) begin
      logic [4:0] s2v;
      logic [4:0] e_old;
      logic [3:0] ev;
      int         ones;
      bit         all_diff;
      if (!reset) begin
         sq.delete();
         sq.push_back(5'd0);
         sq.push_back(5'd0);
         win.delete();
         m_est = 5'd0;
         m_prev4 = 1'b0;
         m_jogar = 1'b0;
         m_botoes = 4'd0;
         m_blocked = 1'b0;
      end else begin
         s2v = sq.pop_front();
         sq.push_back({jogar_raw, botoes_raw});
         e_old = m_est;
         m_jogar = e_old[4] & ~m_prev4;
         m_prev4 = e_old[4];
         ev = e_old[3:0];
         ones = $countones(ev);
         if (m_blocked) begin
            m_botoes = 4'd0;
            if (ev == 4'd0) m_blocked = 1'b0;
         end else if (m_botoes != 4'd0) begin
            if (ev == 4'd0) m_botoes = 4'd0;
            else if (ev != m_botoes) begin
               m_botoes = 4'd0;
               m_blocked = 1'b1;
            end
         end else if (ones == 1) begin
            m_botoes = ev;
         end else if (ones > 1) begin
            m_blocked = 1'b1;
         end
         win.push_back(s2v);
         if (win.size() > D) void'(win.pop_front());
         if (win.size() == D) begin
            for (int i = 0; i < 5; i++) begin
               all_diff = 1'b1;
               foreach (win[w])
                  if (win[w][i] == e_old[i]) all_diff = 1'b0;
               if (all_diff) m_est[i] = ~e_old[i];
            end
         end
      end
   end

   wire [12:0] dut_b = {botoes, jogar, db_estavel, db_multipla, db_estado};
   wire [1:0]  m_st  = m_blocked ? 2'd2 :
                       (m_botoes != 4'd0 ? 2'd1 : 2'd0);
   wire [12:0] exp_b = {m_botoes, m_jogar, m_est, m_blocked, m_st};

   task automatic idle(input int n);
      botoes_raw = 4'd0;
      jogar_raw = 1'b0;
      repeat (n) @(negedge clock);
   endtask

   task automatic test_reset();
      botoes_raw = 4'b0010;
      for (int j = 1; j <= 10; j++) begin
         @(negedge clock);
         checks++;
         if (dut_b !== exp_b) begin
            errors++;
            $display("FAIL reset_pre got %h expected %h", dut_b, exp_b);
         end
      end
      checks++;
      if (botoes !== 4'b0010) begin
         errors++;
         $display("FAIL reset_held got %b expected 0010", botoes);
      end
      #2 reset = 1'b0;
      #1;
      checks++;
      if (dut_b !== 13'd0) begin
         errors++;
         $display("FAIL reset_async got %h expected 0", dut_b);
      end
      @(negedge clock);
      @(negedge clock);
      reset = 1'b1;
      for (int j = 1; j <= 9; j++) begin
         @(negedge clock);
         checks++;
         if (dut_b !== exp_b) begin
            errors++;
            $display("FAIL reset_model j=%0d got %h expected %h",
                     j, dut_b, exp_b);
         end
         checks++;
         if (botoes !== (j >= 7 ? 4'b0010 : 4'b0000)) begin
            errors++;
            $display("FAIL reset_latency j=%0d got %b", j, botoes);
         end
      end
      idle(12);
   endtask

   task automatic test_press_release();
      botoes_raw = 4'b0100;
      for (int j = 1; j <= 9; j++) begin
         @(negedge clock);
         checks++;
         if (dut_b !== exp_b) begin
            errors++;
            $display("FAIL press_model got %h expected %h", dut_b, exp_b);
         end
         checks++;
         if (botoes !== (j >= 7 ? 4'b0100 : 4'b0000)) begin
            errors++;
            $display("FAIL press_latency j=%0d got %b", j, botoes);
         end
      end
      botoes_raw = 4'b0000;
      for (int j = 1; j <= 9; j++) begin
         @(negedge clock);
         checks++;
         if (dut_b !== exp_b) begin
            errors++;
            $display("FAIL release_model got %h expected %h", dut_b, exp_b);
         end
         checks++;
         if (botoes !== (j >= 7 ? 4'b0000 : 4'b0100)) begin
            errors++;
            $display("FAIL release_latency j=%0d got %b", j, botoes);
         end
      end
      checks++;
      if (db_estado !== 2'd0) begin
         errors++;
         $display("FAIL release_state got %0d expected 0", db_estado);
      end
   endtask

   task automatic test_glitch();
      logic pat [7];
      pat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      for (int j = 0; j < 19; j++) begin
         botoes_raw[0] = (j < 7) ? pat[j] : 1'b0;
         @(negedge clock);
         checks++;
         if (dut_b !== exp_b) begin
            errors++;
            $display("FAIL glitch_model got %h expected %h", dut_b, exp_b);
         end
         checks++;
         if (botoes !== 4'd0 || db_estavel[0] !== 1'b0) begin
            errors++;
            $display("FAIL glitch_reject got %b/%b expected 0000/0",
                     botoes, db_estavel[0]);
         end
      end
   endtask

   task automatic test_multi();
      botoes_raw = 4'b0001;
      repeat (9) @(negedge clock);
      checks++;
      if (botoes !== 4'b0001) begin
         errors++;
         $display("FAIL multi_first got %b expected 0001", botoes);
      end
      botoes_raw = 4'b0011;
      for (int j = 1; j <= 9; j++) begin
         @(negedge clock);
         checks++;
         if (dut_b !== exp_b) begin
            errors++;
            $display("FAIL multi_model got %h expected %h", dut_b, exp_b);
         end
      end
      checks++;
      if (botoes !== 4'd0 || db_multipla !== 1'b1) begin
         errors++;
         $display("FAIL multi_block got %b/%b expected 0000/1",
                  botoes, db_multipla);
      end
      botoes_raw = 4'b0001;
      for (int j = 1; j <= 9; j++) begin
         @(negedge clock);
         checks++;
         if (botoes !== 4'd0) begin
            errors++;
            $display("FAIL multi_remain got %b expected 0000", botoes);
         end
      end
      botoes_raw = 4'b0000;
      for (int j = 1; j <= 9; j++) begin
         @(negedge clock);
         checks++;
         if (db_multipla !== (j >= 7 ? 1'b0 : 1'b1)) begin
            errors++;
            $display("FAIL multi_clear j=%0d got %b", j, db_multipla);
         end
      end
      botoes_raw = 4'b1001;
      for (int j = 1; j <= 20; j++) begin
         if (j == 11) botoes_raw = 4'b0000;
         @(negedge clock);
         checks++;
         if (dut_b !== exp_b || botoes !== 4'd0) begin
            errors++;
            $display("FAIL multi_simul got %h expected %h", dut_b, exp_b);
         end
      end
   endtask

   task automatic test_jogar();
      int pulses;
      int first;
      pulses = 0;
      first = -1;
      jogar_raw = 1'b1;
      for (int j = 1; j <= 50; j++) begin
         @(negedge clock);
         checks++;
         if (dut_b !== exp_b) begin
            errors++;
            $display("FAIL jogar_model got %h expected %h", dut_b, exp_b);
         end
         if (jogar === 1'b1) begin
            pulses++;
            if (first < 0) first = j;
         end
      end
      checks++;
      if (pulses != 1 || first != 7) begin
         errors++;
         $display("FAIL jogar_pulse got %0d@%0d expected 1@7",
                  pulses, first);
      end
      jogar_raw = 1'b0;
      pulses = 0;
      for (int j = 1; j <= 15; j++) begin
         @(negedge clock);
         if (jogar !== 1'b0) pulses++;
      end
      checks++;
      if (pulses != 0) begin
         errors++;
         $display("FAIL jogar_release got %0d expected 0", pulses);
      end
   endtask

   task automatic test_bounce();
      int pulses;
      int first;
      pulses = 0;
      first = -1;
      for (int j = 0; j < 10; j++) begin
         jogar_raw = ~jogar_raw;
         @(negedge clock);
         if (jogar === 1'b1) pulses++;
      end
      jogar_raw = 1'b1;
      for (int j = 1; j <= 20; j++) begin
         @(negedge clock);
         checks++;
         if (dut_b !== exp_b) begin
            errors++;
            $display("FAIL bounce_model got %h expected %h", dut_b, exp_b);
         end
         if (jogar === 1'b1) begin
            pulses++;
            if (first < 0) first = j;
         end
      end
      checks++;
      if (pulses != 1 || first != 7) begin
         errors++;
         $display("FAIL bounce_pulse got %0d@%0d expected 1@7",
                  pulses, first);
      end
      idle(15);
   endtask

   task automatic test_random();
      int hold;
      hold = 0;
      for (int c = 0; c < 600; c++) begin
         @(negedge clock);
         checks++;
         if (dut_b !== exp_b) begin
            errors++;
            $display("FAIL random c=%0d got %h expected %h",
                     c, dut_b, exp_b);
         end
         if (hold == 0) begin
            case ($urandom_range(0, 3))
               0: botoes_raw = 4'd0;
               1: botoes_raw = 4'b0001 << $urandom_range(0, 3);
               default: botoes_raw = 4'($urandom);
            endcase
            jogar_raw = 1'($urandom);
            hold = $urandom_range(1, 9);
         end else begin
            hold--;
         end
      end
   endtask

   initial begin
      repeat (3) @(negedge clock);
      reset = 1'b1;
      idle(4);
      test_reset();
      test_press_release();
      test_glitch();
      idle(10);
      test_multi();
      idle(10);
      test_jogar();
      idle(10);
      test_bounce();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
